// File: rtl/fft_pkg.sv
// fft_pkg: shared constants for the FFT result post-processing blocks.
//   WORD_SIZE_DEF  default sample / magnitude width
//   ADDR_WIDTH_DEF default bin address width
//   ST_*           scan controller state encoding (2-bit, legacy-compatible)
//   MAG_MIN_SHIFT  right shift applied to min(|re|,|im|) in the magnitude estimate
package fft_pkg;

  localparam int WORD_SIZE_DEF  = 16;
  localparam int ADDR_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam int MAG_MIN_SHIFT = 2;

endpackage

// File: rtl/mag_approx.sv
// mag_approx: combinational alpha-max-beta-min magnitude estimate.
//   re_i  signed real part
//   im_i  signed imaginary part
//   mag_o unsigned max(|re|,|im|) + (min(|re|,|im|) >> MAG_MIN_SHIFT)
// |-2^(W-1)| is 2^(W-1), which fits the unsigned result, and the sum
// cannot exceed 2^(W-1) + 2^(W-3), so no overflow handling is needed.
module mag_approx
  import fft_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic signed [WORD_SIZE-1:0] re_i,
  input  logic signed [WORD_SIZE-1:0] im_i,
  output logic        [WORD_SIZE-1:0] mag_o
);

  logic [WORD_SIZE-1:0] abs_re;
  logic [WORD_SIZE-1:0] abs_im;
  logic [WORD_SIZE-1:0] hi;
  logic [WORD_SIZE-1:0] lo;

  always_comb begin
    // Two's-complement negate reinterpreted as unsigned, so the most
    // negative input maps to 2^(W-1) rather than wrapping.
    abs_re = re_i[WORD_SIZE-1] ? $unsigned(-re_i) : $unsigned(re_i);
    abs_im = im_i[WORD_SIZE-1] ? $unsigned(-im_i) : $unsigned(im_i);
    if (abs_re >= abs_im) begin
      hi = abs_re;
      lo = abs_im;
    end else begin
      hi = abs_im;
      lo = abs_re;
    end
    // Shift before the add.
    mag_o = hi + (lo >> MAG_MIN_SHIFT);
  end

endmodule

// File: rtl/spectrum_scan_ctrl.sv
// spectrum_scan_ctrl: walks one FFT frame from the result RAM, writes an
// approximate magnitude per bin into the spectrum buffer and reports the
// frame's peak bin.
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle pulse: frame ready in result RAM
//   rd_addr/rd_en     result RAM read port (rd_re/rd_im valid 1 cycle later)
//   rd_re/rd_im       signed result RAM data
//   wr_en/wr_addr/wr_data  spectrum buffer write port (one bin per cycle)
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle pulse the cycle after the final write
//   peak_mag/peak_bin peak of the last completed frame
//   dbg_state_o       current FSM state (ST_* encoding)
//
// Handshake: there is no back-pressure. rd_en high in cycle t means the RAM
// presents rd_re/rd_im for rd_addr in cycle t+1; the magnitude is registered
// at the end of t+1 and appears as wr_en/wr_addr/wr_data in cycle t+2. The
// spectrum buffer must accept every cycle wr_en is high.
//
// N_BINS must satisfy 1 <= N_BINS <= 2**ADDR_WIDTH.
module spectrum_scan_ctrl
  import fft_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int N_BINS     = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic                        rd_en,
  input  logic signed [WORD_SIZE-1:0] rd_re,
  input  logic signed [WORD_SIZE-1:0] rd_im,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [WORD_SIZE-1:0]        wr_data,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_SIZE-1:0]        peak_mag,
  output logic [ADDR_WIDTH-1:0]       peak_bin,
  output logic [1:0]                  dbg_state_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(N_BINS - 1);

  // FSM and read port
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Stage 1: tracks which bin the RAM is presenting this cycle
  logic                  s1_valid_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q;

  // Stage 2: registered write port
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WORD_SIZE-1:0]  wr_data_q;

  // Running peak of the frame in progress and the published peak
  logic [WORD_SIZE-1:0]  run_mag_q, run_mag_d;
  logic [ADDR_WIDTH-1:0] run_bin_q, run_bin_d;
  logic [WORD_SIZE-1:0]  peak_mag_q;
  logic [ADDR_WIDTH-1:0] peak_bin_q;

  logic [WORD_SIZE-1:0]  mag;
  logic                  scan_start;

  mag_approx #(
    .WORD_SIZE(WORD_SIZE)
  ) u_mag (
    .re_i (rd_re),
    .im_i (rd_im),
    .mag_o(mag)
  );

  assign scan_start = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = rd_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SCAN;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SCAN: begin
        if (rd_addr_q == LAST_BIN) begin
          state_d = ST_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Leave once the final bin's write is on the port; done then
        // follows in the next cycle.
        if (wr_en_q && (wr_addr_q == LAST_BIN)) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Strict compare keeps the lowest bin on ties.
  always_comb begin
    run_mag_d = run_mag_q;
    run_bin_d = run_bin_q;
    if (scan_start) begin
      run_mag_d = '0;
      run_bin_d = '0;
    end else if (s1_valid_q && (mag > run_mag_q)) begin
      run_mag_d = mag;
      run_bin_d = s1_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      run_mag_q  <= '0;
      run_bin_q  <= '0;
      peak_mag_q <= '0;
      peak_bin_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s1_valid_q <= rd_en_q;
      s1_addr_q  <= rd_addr_q;
      wr_en_q    <= s1_valid_q;
      wr_addr_q  <= s1_addr_q;
      wr_data_q  <= s1_valid_q ? mag : wr_data_q;
      run_mag_q  <= run_mag_d;
      run_bin_q  <= run_bin_d;
      // The running peak is complete by FINISH; publish it there so the
      // visible peak never reflects a partial frame.
      if (state_q == ST_FINISH) begin
        peak_mag_q <= run_mag_q;
        peak_bin_q <= run_bin_q;
      end
    end
  end

  assign rd_addr     = rd_addr_q;
  assign rd_en       = rd_en_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign peak_mag    = peak_mag_q;
  assign peak_bin    = peak_bin_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spectrum_scan_ctrl.sv
// tb_spectrum_scan_ctrl: frame-level bench for spectrum_scan_ctrl with a
// result RAM model, a per-frame expected-write queue and a peak model.
module tb_spectrum_scan_ctrl;

  localparam int W  = 16;
  localparam int AW = 8;
  localparam int NB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 start;
  logic [AW-1:0]        rd_addr;
  logic                 rd_en;
  logic signed [W-1:0]  rd_re;
  logic signed [W-1:0]  rd_im;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [W-1:0]         wr_data;
  logic                 busy;
  logic                 done;
  logic [W-1:0]         peak_mag;
  logic [AW-1:0]        peak_bin;
  logic [1:0]           dbg_state;

  spectrum_scan_ctrl #(
    .WORD_SIZE (W),
    .ADDR_WIDTH(AW),
    .N_BINS    (NB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_re      (rd_re),
    .rd_im      (rd_im),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .peak_mag   (peak_mag),
    .peak_bin   (peak_bin),
    .dbg_state_o(dbg_state)
  );

  // ---------------- result RAM model ----------------
  logic signed [W-1:0] mem_re [256];
  logic signed [W-1:0] mem_im [256];

  // Garbage on the data bus whenever no read was issued.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_re <= mem_re[rd_addr];
      rd_im <= mem_im[rd_addr];
    end else begin
      rd_re <= W'($urandom);
      rd_im <= W'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int prev_peak_mag = 0;
  int prev_peak_bin = 0;
  logic [AW+W-1:0] exp_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int ref_mag(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a >= b) return a + b / 4;
    else        return b + a / 4;
  endfunction

  function automatic logic signed [W-1:0] rand_sample(input int mode);
    int pick;
    case (mode)
      1: return W'($signed($urandom_range(0, 6)) - 3);
      2: begin
        pick = $urandom_range(0, 2);
        if (pick == 0)      return 16'sh8000;
        else if (pick == 1) return 16'sh7fff;
        else                return 16'sh0000;
      end
      default: return W'($urandom);
    endcase
  endfunction

  task automatic fill_random(input int mode);
    for (int k = 0; k < NB; k++) begin
      mem_re[k] = rand_sample(mode);
      mem_im[k] = rand_sample(mode);
    end
  endtask

  task automatic set_bin(input int k, input int re, input int im);
    mem_re[k] = W'(re);
    mem_im[k] = W'(im);
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end at a falling edge.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_wr_en", wr_en, 0);
    end
  endtask

  // Cycle 0 carries the start pulse; writes expected in cycles 3..NB+2,
  // done in NB+3, idle with the new peak in NB+4. restart_cyc != 0 raises
  // start again during that cycle, which must be ignored.
  task automatic run_frame(input int restart_cyc);
    int m, exp_peak, exp_bin, wr_idx, dones;
    logic [AW+W-1:0] e;
    exp_q.delete();
    exp_peak = 0;
    exp_bin  = 0;
    for (int k = 0; k < NB; k++) begin
      m = ref_mag(int'(mem_re[k]), int'(mem_im[k]));
      exp_q.push_back({AW'(k), W'(m)});
      if (m > exp_peak) begin
        exp_peak = m;
        exp_bin  = k;
      end
    end
    wr_idx = 0;
    dones  = 0;
    start  = 1'b1;
    for (int cyc = 1; cyc <= NB + 4; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_cyc);
      check("busy", busy, (cyc <= NB + 3) ? 1 : 0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", cyc, 3 + wr_idx);
          check("wr_addr", wr_addr, e[AW+W-1:W]);
          check("wr_data", wr_data, e[W-1:0]);
          wr_idx++;
        end
      end
      if (done) begin
        dones++;
        check("done_cycle", cyc, NB + 3);
        check("peak_hold_mag", peak_mag, prev_peak_mag);
        check("peak_hold_bin", peak_bin, prev_peak_bin);
      end
    end
    start = 1'b0;
    check("writes_missing", exp_q.size(), 0);
    check("done_count", dones, 1);
    check("peak_mag", peak_mag, exp_peak);
    check("peak_bin", peak_bin, exp_bin);
    prev_peak_mag = exp_peak;
    prev_peak_bin = exp_bin;
  endtask

  // Reset lands while bin 2 is on the write port.
  task automatic mid_reset();
    start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_wr_en_before", wr_en, 1);
    check("mid_wr_addr_before", wr_addr, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_wr_en", wr_en, 0);
    check("mid_busy", busy, 0);
    check("mid_rd_en", rd_en, 0);
    check("mid_peak_mag", peak_mag, 0);
    check("mid_peak_bin", peak_bin, 0);
    prev_peak_mag = 0;
    prev_peak_bin = 0;
    idle_cycles(8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 256; k++) begin
      mem_re[k] = '0;
      mem_im[k] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_peak_mag", peak_mag, 0);
    check("rst_peak_bin", peak_bin, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    idle_cycles(2);

    // Constant frame re=3, im=-4
    for (int k = 0; k < NB; k++) set_bin(k, 3, -4);
    run_frame(0);
    check("t1_peak_mag", peak_mag, 4);
    check("t1_peak_bin", peak_bin, 0);
    idle_cycles(2);

    // Arithmetic edges
    set_bin(0, -32768, 0);
    set_bin(1, -32768, -32768);
    set_bin(2, 0, 0);
    set_bin(3, 1, -1);
    check("edge_ref0", ref_mag(-32768, 0), 32768);
    check("edge_ref1", ref_mag(-32768, -32768), 40960);
    check("edge_ref3", ref_mag(1, -1), 1);
    run_frame(0);
    check("t2_peak_mag", peak_mag, 40960);
    check("t2_peak_bin", peak_bin, 1);
    idle_cycles(1);

    // Peak tie keeps the lowest bin
    set_bin(0, 5, 0);
    set_bin(1, 0, 9);
    set_bin(2, 9, 0);
    set_bin(3, 2, 2);
    run_frame(0);
    check("t3_peak_mag", peak_mag, 9);
    check("t3_peak_bin", peak_bin, 1);
    idle_cycles(1);

    // Start during busy is ignored
    fill_random(0);
    run_frame(2);
    idle_cycles(3);

    // Reset mid-scan, then a clean frame
    fill_random(0);
    mid_reset();
    fill_random(0);
    run_frame(0);
    idle_cycles(1);

    // Back-to-back frames
    fill_random(0);
    run_frame(0);
    fill_random(1);
    run_frame(0);
    idle_cycles(1);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      fill_random($urandom_range(0, 3));
      run_frame(($urandom_range(0, 1) == 1) ? $urandom_range(2, NB + 3) : 0);
      idle_cycles($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
